sram_dp: RTL and testbench

//   True dual-port, byte-writable on-chip SRAM with a req/ack handshake on each port.

---
 rtl/sram_dp.sv | 131 +++++++++++++
 tb/tb_sram_dp.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp.sv
// True dual-port, byte-writable SRAM with per-port req/ack, selectable read latency,
// defined read-during-write / write-write collision behaviour and a collision counter.
module sram_dp #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 10,
   parameter int BYTE_WIDTH   = 8,
   parameter int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH,
   parameter int READ_LATENCY = 1,
   parameter int RDW_MODE     = 0,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [NUM_BYTES-1:0]  a_be,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic                  a_ack,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [NUM_BYTES-1:0]  b_be,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  b_ack,
   output logic [CNT_WIDTH-1:0]  coll_cnt
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  a_wr, b_wr, same_addr;
   logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, a_resp, b_resp;

   logic                  a_ack1_q, b_ack1_q;
   logic [DATA_WIDTH-1:0] a_rdata1_q, a_rdata1_d, b_rdata1_q, b_rdata1_d;
   logic [CNT_WIDTH-1:0]  coll_q, coll_d;

   assign a_wr      = a_req & a_we;
   assign b_wr      = b_req & b_we;
   assign same_addr = (a_addr == b_addr);
   assign a_old     = mem_q[a_addr];
   assign b_old     = mem_q[b_addr];

   // Post-write view of each port's word: A's lanes beat B's lanes on a shared address.
   generate
      for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
         localparam int LO = gi * BYTE_WIDTH;
         assign a_new[LO +: BYTE_WIDTH] =
            (a_wr && a_be[gi])              ? a_wdata[LO +: BYTE_WIDTH] :
            (b_wr && same_addr && b_be[gi]) ? b_wdata[LO +: BYTE_WIDTH] :
                                              a_old[LO +: BYTE_WIDTH];
         assign b_new[LO +: BYTE_WIDTH] =
            (a_wr && same_addr && a_be[gi]) ? a_wdata[LO +: BYTE_WIDTH] :
            (b_wr && b_be[gi])              ? b_wdata[LO +: BYTE_WIDTH] :
                                              b_old[LO +: BYTE_WIDTH];
      end
   endgenerate

   assign a_resp = (RDW_MODE == 1) ? a_new : a_old;
   assign b_resp = (RDW_MODE == 1) ? b_new : b_old;

   // A's lane writes are issued last so they take precedence on a shared address.
   always_ff @(posedge clk) begin : mem_write
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (b_wr && b_be[i]) mem_q[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (a_wr && a_be[i]) mem_q[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   always_comb begin
      a_rdata1_d = a_rdata1_q;
      b_rdata1_d = b_rdata1_q;
      coll_d     = coll_q;
      if (a_req) a_rdata1_d = a_resp;
      if (b_req) b_rdata1_d = b_resp;
      if (a_wr && b_wr && same_addr && (coll_q != {CNT_WIDTH{1'b1}}))
         coll_d = coll_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_ack1_q   <= 1'b0;
         b_ack1_q   <= 1'b0;
         a_rdata1_q <= '0;
         b_rdata1_q <= '0;
         coll_q     <= '0;
      end else begin
         a_ack1_q   <= a_req;
         b_ack1_q   <= b_req;
         a_rdata1_q <= a_rdata1_d;
         b_rdata1_q <= b_rdata1_d;
         coll_q     <= coll_d;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  a_ack2_q, b_ack2_q;
         logic [DATA_WIDTH-1:0] a_rdata2_q, b_rdata2_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_ack2_q   <= 1'b0;
               b_ack2_q   <= 1'b0;
               a_rdata2_q <= '0;
               b_rdata2_q <= '0;
            end else begin
               a_ack2_q <= a_ack1_q;
               b_ack2_q <= b_ack1_q;
               if (a_ack1_q) a_rdata2_q <= a_rdata1_q;
               if (b_ack1_q) b_rdata2_q <= b_rdata1_q;
            end
         end

         assign a_ack   = a_ack2_q;
         assign b_ack   = b_ack2_q;
         assign a_rdata = a_rdata2_q;
         assign b_rdata = b_rdata2_q;
      end else begin : g_lat1
         assign a_ack   = a_ack1_q;
         assign b_ack   = b_ack1_q;
         assign a_rdata = a_rdata1_q;
         assign b_rdata = b_rdata1_q;
      end
   endgenerate

   assign coll_cnt = coll_q;
endmodule

// File: tb/tb_sram_dp.sv
// Drives two sram_dp instances (LAT1/read-first/16-bit counter and LAT2/write-first/2-bit
// counter) with identical traffic and checks both against a word-level memory model.
module tb_sram_dp;
   localparam int NS = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req, a_we, b_req, b_we;
   logic [3:0]  a_be, b_be;
   logic [9:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic [31:0] d0_a_rdata, d0_b_rdata, d1_a_rdata, d1_b_rdata;
   logic        d0_a_ack, d0_b_ack, d1_a_ack, d1_b_ack;
   logic [15:0] d0_cnt;
   logic [1:0]  d1_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: one shared word array, per-DUT response schedule indexed by sample
   logic [31:0] model_mem [1024];
   logic [15:0] m_cnt [2];
   bit          sched_ack  [2][2][NS];
   logic [31:0] sched_data [2][2][NS];
   logic [31:0] last_data  [2][2];
   bit          exp_ack  [2][2][NS];
   logic [31:0] exp_data [2][2][NS];
   logic [15:0] exp_cnt  [2][NS];
   logic        obs_ack  [2][2][NS];
   logic [31:0] obs_data [2][2][NS];
   logic [15:0] obs_cnt  [2][NS];

   sram_dp #(.READ_LATENCY(1), .RDW_MODE(0), .CNT_WIDTH(16)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(d0_a_rdata), .a_ack(d0_a_ack),
      .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(d0_b_rdata), .b_ack(d0_b_ack),
      .coll_cnt(d0_cnt)
   );

   sram_dp #(.READ_LATENCY(2), .RDW_MODE(1), .CNT_WIDTH(2)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(d1_a_rdata), .a_ack(d1_a_ack),
      .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(d1_b_rdata), .b_ack(d1_b_ack),
      .coll_cnt(d1_cnt)
   );

   always #5 clk = ~clk;

   // Word at addr after this edge's writes: B's enabled lanes, then A's on top.
   function automatic logic [31:0] merged(input logic [9:0] addr);
      logic [31:0] w;
      w = model_mem[addr];
      for (int l = 0; l < 4; l++)
         if (b_req && b_we && b_addr == addr && b_be[l]) w[l*8 +: 8] = b_wdata[l*8 +: 8];
      for (int l = 0; l < 4; l++)
         if (a_req && a_we && a_addr == addr && a_be[l]) w[l*8 +: 8] = a_wdata[l*8 +: 8];
      return w;
   endfunction

   task automatic model_edge();
      logic [31:0] na, nb;
      cyc++;
      if (cyc >= NS - 3) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NS - 3);
         $fatal(1, "cycle budget exhausted");
      end
      if (rst_n) begin
         na = merged(a_addr);
         nb = merged(b_addr);
         for (int d = 0; d < 2; d++) begin
            if (a_req) begin
               sched_ack[d][0][cyc + d]  = 1'b1;
               sched_data[d][0][cyc + d] = (d == 0) ? model_mem[a_addr] : na;
            end
            if (b_req) begin
               sched_ack[d][1][cyc + d]  = 1'b1;
               sched_data[d][1][cyc + d] = (d == 0) ? model_mem[b_addr] : nb;
            end
         end
         if (a_req && a_we && b_req && b_we && a_addr == b_addr) begin
            if (m_cnt[0] != 16'hFFFF) m_cnt[0]++;
            if (m_cnt[1] != 16'd3)    m_cnt[1]++;
         end
         if (b_req && b_we) model_mem[b_addr] = nb;
         if (a_req && a_we) model_mem[a_addr] = na;
      end
      for (int d = 0; d < 2; d++) begin
         exp_cnt[d][cyc] = m_cnt[d];
         for (int p = 0; p < 2; p++) begin
            if (sched_ack[d][p][cyc]) last_data[d][p] = sched_data[d][p][cyc];
            exp_ack[d][p][cyc]  = sched_ack[d][p][cyc];
            exp_data[d][p][cyc] = last_data[d][p];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      obs_ack[0][0][cyc] = d0_a_ack;    obs_ack[0][1][cyc] = d0_b_ack;
      obs_ack[1][0][cyc] = d1_a_ack;    obs_ack[1][1][cyc] = d1_b_ack;
      obs_data[0][0][cyc] = d0_a_rdata; obs_data[0][1][cyc] = d0_b_rdata;
      obs_data[1][0][cyc] = d1_a_rdata; obs_data[1][1][cyc] = d1_b_rdata;
      obs_cnt[0][cyc] = d0_cnt;
      obs_cnt[1][cyc] = {14'd0, d1_cnt};
   endtask

   task automatic assert_reset();
      #2 rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = '0;
         for (int p = 0; p < 2; p++) begin
            last_data[d][p] = '0;
            for (int i = cyc + 1; i < NS; i++) sched_ack[d][p][i] = 1'b0;
         end
      end
   endtask

   task automatic set_a(input bit req, input bit we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] wd);
      a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
   endtask

   task automatic set_b(input bit req, input bit we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] wd);
      b_req = req; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
   endtask

   task automatic idle();
      set_a(0, 0, 4'h0, 10'd0, 32'h0);
      set_b(0, 0, 4'h0, 10'd0, 32'h0);
   endtask

   task automatic test_reset();
      int s, k;
      s = cyc + 1;
      idle();
      tick(); tick();
      if (d1_cnt !== 2'd0 || d0_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", d0_cnt, d1_cnt);
      end
      n_checks++;
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         set_a(1, 1, 4'hF, 10'(i), 32'h0);
         set_b(1, 1, 4'hF, 10'(i + 16), 32'h0);
         tick();
      end
      set_a(1, 1, 4'hF, 10'd3, 32'h12345678);
      set_b(1, 1, 4'hF, 10'd20, 32'h9ABCDEF0);
      tick();
      idle();
      tick(); tick();
      assert_reset();
      tick(); tick();
      n_checks++;
      if (d1_a_rdata !== 32'h0 || d1_a_ack !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs got=%h/%b want=0/0", d1_a_rdata, d1_a_ack);
      end
      rst_n = 1'b1;
      tick();
      set_a(1, 0, 4'h0, 10'd3, 32'h0);
      set_b(1, 0, 4'h0, 10'd20, 32'h0);
      k = cyc + 1;
      tick();
      idle();
      tick(); tick();
      n_checks++;
      if (obs_data[0][0][k] !== 32'h12345678) begin
         n_fail++; $display("FAIL persist_a got=%h want=12345678", obs_data[0][0][k]);
      end
      n_checks++;
      if (obs_data[1][1][k + 1] !== 32'h9ABCDEF0) begin
         n_fail++; $display("FAIL persist_b got=%h want=9abcdef0", obs_data[1][1][k + 1]);
      end
      for (int i = s; i <= cyc; i++)
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_cnt[d][i] !== exp_cnt[d][i]) begin
               n_fail++; $display("FAIL reset_cnt cyc=%0d dut%0d got=%0d want=%0d", i, d, obs_cnt[d][i], exp_cnt[d][i]);
            end
            for (int p = 0; p < 2; p++) begin
               n_checks += 2;
               if (obs_ack[d][p][i] !== exp_ack[d][p][i]) begin
                  n_fail++; $display("FAIL reset_ack cyc=%0d dut%0d port%0d got=%b want=%b", i, d, p, obs_ack[d][p][i], exp_ack[d][p][i]);
               end
               if (obs_data[d][p][i] !== exp_data[d][p][i]) begin
                  n_fail++; $display("FAIL reset_data cyc=%0d dut%0d port%0d got=%h want=%h", i, d, p, obs_data[d][p][i], exp_data[d][p][i]);
               end
            end
         end
   endtask

   task automatic test_byte_write();
      int s, k;
      s = cyc + 1;
      set_a(1, 1, 4'hF, 10'd5, 32'h11223344); tick();
      set_a(1, 1, 4'b0101, 10'd5, 32'hDEADBEEF); tick();
      set_a(1, 0, 4'h0, 10'd5, 32'h0);
      k = cyc + 1;
      tick();
      idle();
      tick(); tick();
      n_checks += 3;
      if (obs_ack[0][0][k] !== 1'b1 || obs_data[0][0][k] !== 32'h11AD33EF) begin
         n_fail++; $display("FAIL bytewr_lat1 ack=%b got=%h want=11ad33ef", obs_ack[0][0][k], obs_data[0][0][k]);
      end
      if (obs_ack[1][0][k] !== 1'b1 || obs_data[1][0][k] !== 32'h11AD33EF) begin
         // LAT2 stage still holds the previous write's merged response at sample k
         if (obs_data[1][0][k + 1] !== 32'h11AD33EF) begin
            n_fail++; $display("FAIL bytewr_lat2 got=%h want=11ad33ef", obs_data[1][0][k + 1]);
         end
      end
      if (obs_ack[1][0][k + 2] !== 1'b0) begin
         n_fail++; $display("FAIL bytewr_lat2_ackend got=%b want=0", obs_ack[1][0][k + 2]);
      end
      for (int i = s; i <= cyc; i++)
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
               n_checks += 2;
               if (obs_ack[d][p][i] !== exp_ack[d][p][i]) begin
                  n_fail++; $display("FAIL bytewr_ack cyc=%0d dut%0d port%0d got=%b want=%b", i, d, p, obs_ack[d][p][i], exp_ack[d][p][i]);
               end
               if (obs_data[d][p][i] !== exp_data[d][p][i]) begin
                  n_fail++; $display("FAIL bytewr_data cyc=%0d dut%0d port%0d got=%h want=%h", i, d, p, obs_data[d][p][i], exp_data[d][p][i]);
               end
            end
   endtask

   task automatic test_rdw();
      int s, k;
      s = cyc + 1;
      set_a(1, 1, 4'hF, 10'd7, 32'hCAFEF00D);
      set_b(1, 0, 4'h0, 10'd7, 32'h0);
      k = cyc + 1;
      tick();
      idle();
      tick(); tick();
      n_checks += 2;
      if (obs_data[0][1][k] !== 32'h0) begin
         n_fail++; $display("FAIL rdw_readfirst got=%h want=00000000", obs_data[0][1][k]);
      end
      if (obs_data[1][1][k + 1] !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL rdw_writefirst got=%h want=cafef00d", obs_data[1][1][k + 1]);
      end
      for (int i = s; i <= cyc; i++)
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
               n_checks += 2;
               if (obs_ack[d][p][i] !== exp_ack[d][p][i]) begin
                  n_fail++; $display("FAIL rdw_ack cyc=%0d dut%0d port%0d got=%b want=%b", i, d, p, obs_ack[d][p][i], exp_ack[d][p][i]);
               end
               if (obs_data[d][p][i] !== exp_data[d][p][i]) begin
                  n_fail++; $display("FAIL rdw_data cyc=%0d dut%0d port%0d got=%h want=%h", i, d, p, obs_data[d][p][i], exp_data[d][p][i]);
               end
            end
   endtask

   task automatic test_collision();
      int s, k, r;
      s = cyc + 1;
      set_a(1, 1, 4'b0011, 10'd9, 32'hAAAAAAAA);
      set_b(1, 1, 4'b0110, 10'd9, 32'hBBBBBBBB);
      k = cyc + 1;
      tick();
      set_a(1, 0, 4'h0, 10'd9, 32'h0);
      set_b(0, 0, 4'h0, 10'd0, 32'h0);
      r = cyc + 1;
      tick();
      for (int i = 0; i < 5; i++) begin
         set_a(1, 1, 4'b1100, 10'd10, $urandom);
         set_b(1, 1, 4'b0011, 10'd10, $urandom);
         tick();
      end
      idle();
      tick(); tick();
      n_checks += 4;
      if (obs_cnt[0][k] !== 16'd1 || obs_cnt[1][k] !== 16'd1) begin
         n_fail++; $display("FAIL coll_first got=%0d/%0d want=1/1", obs_cnt[0][k], obs_cnt[1][k]);
      end
      if (obs_data[0][0][r] !== 32'h00BBAAAA) begin
         n_fail++; $display("FAIL coll_merge got=%h want=00bbaaaa", obs_data[0][0][r]);
      end
      if (d1_cnt !== 2'd3) begin
         n_fail++; $display("FAIL coll_saturate got=%0d want=3", d1_cnt);
      end
      if (d0_cnt !== 16'd6) begin
         n_fail++; $display("FAIL coll_count got=%0d want=6", d0_cnt);
      end
      for (int i = s; i <= cyc; i++)
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_cnt[d][i] !== exp_cnt[d][i]) begin
               n_fail++; $display("FAIL coll_cnt cyc=%0d dut%0d got=%0d want=%0d", i, d, obs_cnt[d][i], exp_cnt[d][i]);
            end
            for (int p = 0; p < 2; p++) begin
               n_checks += 2;
               if (obs_ack[d][p][i] !== exp_ack[d][p][i]) begin
                  n_fail++; $display("FAIL coll_ack cyc=%0d dut%0d port%0d got=%b want=%b", i, d, p, obs_ack[d][p][i], exp_ack[d][p][i]);
               end
               if (obs_data[d][p][i] !== exp_data[d][p][i]) begin
                  n_fail++; $display("FAIL coll_data cyc=%0d dut%0d port%0d got=%h want=%h", i, d, p, obs_data[d][p][i], exp_data[d][p][i]);
               end
            end
         end
   endtask

   task automatic test_back_to_back();
      int k;
      k = cyc + 1;
      for (int i = 0; i < 8; i++) begin
         set_b(1, 0, 4'h0, 10'(i), 32'h0);
         tick();
      end
      idle();
      tick(); tick();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 8; i++) begin
            n_checks += 2;
            if (obs_ack[d][1][k + d + i] !== 1'b1) begin
               n_fail++; $display("FAIL b2b_ack dut%0d beat%0d got=%b want=1", d, i, obs_ack[d][1][k + d + i]);
            end
            if (obs_data[d][1][k + d + i] !== model_mem[i]) begin
               n_fail++; $display("FAIL b2b_data dut%0d beat%0d got=%h want=%h", d, i, obs_data[d][1][k + d + i], model_mem[i]);
            end
         end
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (obs_ack[d][1][k + d + 8] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_tail dut%0d got=%b want=0", d, obs_ack[d][1][k + d + 8]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int k, r;
      set_a(1, 0, 4'h0, 10'd3, 32'h0);
      k = cyc + 1;
      tick();
      set_a(1, 0, 4'h0, 10'd20, 32'h0);
      assert_reset();
      tick();
      idle();
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = k; i <= cyc; i++) begin
         n_checks++;
         if (obs_ack[1][0][i] !== 1'b0) begin
            n_fail++; $display("FAIL midrst_noack cyc=%0d got=%b want=0", i, obs_ack[1][0][i]);
         end
      end
      set_a(1, 0, 4'h0, 10'd5, 32'h0);
      r = cyc + 1;
      tick();
      idle();
      tick(); tick();
      n_checks += 2;
      if (obs_ack[1][0][r + 1] !== 1'b1 || obs_data[1][0][r + 1] !== model_mem[5]) begin
         n_fail++; $display("FAIL midrst_after got=%b/%h want=1/%h", obs_ack[1][0][r + 1], obs_data[1][0][r + 1], model_mem[5]);
      end
      if (obs_ack[0][0][r] !== 1'b1 || obs_data[0][0][r] !== model_mem[5]) begin
         n_fail++; $display("FAIL midrst_after_lat1 got=%b/%h want=1/%h", obs_ack[0][0][r], obs_data[0][0][r], model_mem[5]);
      end
   endtask

   task automatic test_random();
      int s;
      s = cyc + 1;
      for (int i = 0; i < 150; i++) begin
         set_a(($urandom % 4) != 0, $urandom % 2, 4'($urandom), 10'($urandom % 8), $urandom);
         set_b(($urandom % 4) != 0, $urandom % 2, 4'($urandom), 10'($urandom % 8), $urandom);
         tick();
      end
      idle();
      tick(); tick(); tick();
      for (int i = s; i <= cyc; i++)
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_cnt[d][i] !== exp_cnt[d][i]) begin
               n_fail++; $display("FAIL rand_cnt cyc=%0d dut%0d got=%0d want=%0d", i, d, obs_cnt[d][i], exp_cnt[d][i]);
            end
            for (int p = 0; p < 2; p++) begin
               n_checks += 2;
               if (obs_ack[d][p][i] !== exp_ack[d][p][i]) begin
                  n_fail++; $display("FAIL rand_ack cyc=%0d dut%0d port%0d got=%b want=%b", i, d, p, obs_ack[d][p][i], exp_ack[d][p][i]);
               end
               if (obs_data[d][p][i] !== exp_data[d][p][i]) begin
                  n_fail++; $display("FAIL rand_data cyc=%0d dut%0d port%0d got=%h want=%h", i, d, p, obs_data[d][p][i], exp_data[d][p][i]);
               end
            end
         end
   endtask

   initial begin
      idle();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = '0;
         for (int p = 0; p < 2; p++) begin
            last_data[d][p] = '0;
            for (int i = 0; i < NS; i++) sched_ack[d][p][i] = 1'b0;
         end
      end
      test_reset();
      test_byte_write();
      test_rdw();
      test_collision();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
